// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: field widths, the packed
// instruction layout held in the FIFO, and the assembler state encoding.
package instr_loader_pkg;

    localparam int OPC_W   = 3;
    localparam int REG_W   = 3;
    localparam int IMM_W   = 8;
    localparam int INSTR_W = OPC_W + 3 * REG_W + IMM_W;   // 20

    // Bit offsets of each field inside a packed instruction word.
    localparam int IMM_LSB   = 0;
    localparam int SRCB_LSB  = IMM_LSB + IMM_W;
    localparam int SRCA_LSB  = SRCB_LSB + REG_W;
    localparam int DEST_LSB  = SRCA_LSB + REG_W;
    localparam int OPC_LSB   = DEST_LSB + REG_W;

    localparam logic [OPC_W-1:0] OP_NOP = 3'b000;
    localparam logic [OPC_W-1:0] OP_LI  = 3'b111;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] dest;
        logic [REG_W-1:0] src_a;
        logic [REG_W-1:0] src_b;
        logic [IMM_W-1:0] imm;
    } instr_t;

    // Encodes byte_idx: which packet byte is expected next.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_B1   = 2'd1,
        ST_B2   = 2'd2
    } asm_state_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of packed instructions.
// Ports:
//   clk, rst      clock, asynchronous active-low reset (pointers/count only)
//   push, din     write din when push and not full
//   pop, dout     dout shows the head entry; pop advances when not empty
//   full, empty   occupancy flags
//   count         occupancy, 0..DEPTH
module instr_fifo
    import instr_loader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  instr_t                 din,
    input  logic                   pop,
    output instr_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    instr_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        // DEPTH is a power of two, so plain increment wraps the pointers.
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Byte-serial instruction loader: assembles 3-byte packets into instructions,
// queues them, and issues one per enabled cycle to toy_cpu.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_sof/in_data  byte stream in; in_sof marks byte 0
//   in_ready                 byte accepted when in_valid & in_ready
//   issue_en                 pop one queued instruction this cycle if any
//   op_valid, opcode, src_a, src_b, dest, imm   registered issue outputs
//   count                    queue occupancy
//   err                      sticky framing error
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    input  logic                   issue_en,
    output logic                   op_valid,
    output logic [2:0]             opcode,
    output logic [2:0]             src_a,
    output logic [2:0]             src_b,
    output logic [2:0]             dest,
    output logic [7:0]             imm,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);

    asm_state_t state_q, state_d;
    logic       err_q, err_d;
    logic [5:0] hdr_q, hdr_d;      // byte0[7:2]: opcode, dest
    logic [5:0] regs_q, regs_d;    // byte1[7:2]: src_a, src_b

    logic       accept, push, pop;
    logic       fifo_full, fifo_empty;
    instr_t     push_data, fifo_dout;

    logic             op_valid_q, op_valid_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    logic [REG_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dest_q, dest_d;
    logic [IMM_W-1:0] imm_q, imm_d;

    // Only fullness gates byte2; issue_en deliberately has no path here.
    assign in_ready = !((state_q == ST_B2) && fifo_full);

    always_comb begin
        accept  = in_valid && in_ready;
        state_d = state_q;
        err_d   = err_q;
        hdr_d   = hdr_q;
        regs_d  = regs_q;
        push    = 1'b0;

        push_data.opcode = hdr_q[5:3];
        push_data.dest   = hdr_q[2:0];
        push_data.src_a  = regs_q[5:3];
        push_data.src_b  = regs_q[2:0];
        push_data.imm    = in_data;

        if (accept) begin
            if (in_sof) begin
                // A sof outside IDLE abandons the partial packet and restarts.
                if (state_q != ST_IDLE) begin
                    err_d = 1'b1;
                end
                hdr_d   = in_data[7:2];
                state_d = ST_B1;
            end else begin
                case (state_q)
                    ST_IDLE: err_d = 1'b1;   // stray byte: swallowed
                    ST_B1: begin
                        regs_d  = in_data[7:2];
                        state_d = ST_B2;
                    end
                    ST_B2: begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        pop        = issue_en && !fifo_empty;
        op_valid_d = pop;
        opcode_d   = pop ? fifo_dout.opcode : OP_NOP;
        src_a_d    = pop ? fifo_dout.src_a  : src_a_q;
        src_b_d    = pop ? fifo_dout.src_b  : src_b_q;
        dest_d     = pop ? fifo_dout.dest   : dest_q;
        imm_d      = pop ? fifo_dout.imm    : imm_q;
    end

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            err_q      <= 1'b0;
            op_valid_q <= 1'b0;
            opcode_q   <= OP_NOP;
            src_a_q    <= '0;
            src_b_q    <= '0;
            dest_q     <= '0;
            imm_q      <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            op_valid_q <= op_valid_d;
            opcode_q   <= opcode_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            dest_q     <= dest_d;
            imm_q      <= imm_d;
        end
    end

    // Partial-packet bytes are only meaningful once the FSM has advanced.
    always_ff @(posedge clk) begin
        hdr_q  <= hdr_d;
        regs_q <= regs_d;
    end

    assign err      = err_q;
    assign op_valid = op_valid_q;
    assign opcode   = opcode_q;
    assign src_a    = src_a_q;
    assign src_b    = src_b_q;
    assign dest     = dest_q;
    assign imm      = imm_q;

endmodule
